// File: rtl/dds_phase_gen_pkg.sv
// rtl/dds_phase_gen_pkg.sv - shared constants, state encoding and rounding helper for the DDS phase generator
package dds_phase_gen_pkg;

    localparam int unsigned SYS_CLK_HZ = 100_000_000;
    localparam int FREQ_W    = 20;
    localparam int PHASE_W   = 32;
    localparam int FRAC_BITS = 24;
    localparam int K_W       = 30;
    localparam int PROD_W    = FREQ_W + K_W;
    localparam int CNT_W     = $clog2(FREQ_W);

    // round(2^(PHASE_W+FRAC_BITS) / SYS_CLK_HZ) = 720575940
    localparam logic [63:0] FTW_K_FULL =
        ((64'd1 << (PHASE_W + FRAC_BITS)) + 64'(SYS_CLK_HZ / 2)) / 64'(SYS_CLK_HZ);
    localparam logic [K_W-1:0] FTW_K = FTW_K_FULL[K_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_LOAD = 2'd2
    } conv_state_e;

    // Round-half-up then drop the fractional bits; the integer part always fits in PHASE_W.
    function automatic logic [PHASE_W-1:0] round_ftw(input logic [PROD_W-1:0] prod);
        logic [PROD_W-1:0] r;
        r = prod + {{(PROD_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
        return {{(PHASE_W-(PROD_W-FRAC_BITS)){1'b0}}, r[PROD_W-1:FRAC_BITS]};
    endfunction

endpackage

// File: rtl/dds_phase_gen_ftw_mult_seq.sv
// rtl/dds_phase_gen_ftw_mult_seq.sv - LSB-first shift-add multiplier of freq_hz by FTW_K
module dds_phase_gen_ftw_mult_seq
    import dds_phase_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [FREQ_W-1:0] mcand_i,
    output logic              done_o,
    output logic [PROD_W-1:0] product_o
);

    logic [FREQ_W-1:0] mcand_q,   mcand_d;
    logic [PROD_W-1:0] product_q, product_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              run_q,     run_d;
    logic              last_bit;

    assign last_bit = (cnt_q == CNT_W'(FREQ_W - 1));

    always_comb begin
        mcand_d   = mcand_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        if (start_i) begin
            mcand_d   = mcand_i;
            product_d = '0;
            cnt_d     = '0;
            run_d     = 1'b1;
        end else if (run_q) begin
            if (mcand_q[cnt_q]) begin
                product_d = product_q + ({{FREQ_W{1'b0}}, FTW_K} << cnt_q);
            end
            cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
        end
    end

    // Asserted during the cycle whose edge accumulates the final bit.
    assign done_o    = run_q && last_bit;
    assign product_o = product_q;

endmodule

// File: rtl/dds_phase_gen.sv
// rtl/dds_phase_gen.sv - frequency-to-FTW conversion with atomic FTW update and 32-bit phase accumulator
module dds_phase_gen
    import dds_phase_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FREQ_W-1:0]  freq_hz_i,
    input  logic               enable_i,
    input  logic               phase_clear_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               wrap_o,
    output logic [PHASE_W-1:0] ftw_o,
    output logic               busy_o
);

    conv_state_e        state_q;
    logic [FREQ_W-1:0]  freq_latched_q;
    logic [PHASE_W-1:0] ftw_q;
    logic               busy_q;
    logic [PHASE_W-1:0] phase_q;
    logic               wrap_q;

    logic               start;
    logic               mult_done;
    logic [PROD_W-1:0]  product;
    logic [PHASE_W:0]   phase_sum;

    assign start = (state_q == ST_IDLE) && (freq_hz_i != freq_latched_q);

    dds_phase_gen_ftw_mult_seq u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .mcand_i   (freq_hz_i),
        .done_o    (mult_done),
        .product_o (product)
    );

    // ftw_q only changes in LOAD, so the accumulator never sees a partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            freq_latched_q <= '0;
            ftw_q          <= '0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        freq_latched_q <= freq_hz_i;
                        busy_q         <= 1'b1;
                        state_q        <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (mult_done) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ftw_q   <= round_ftw(product);
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign phase_sum = {1'b0, phase_q} + {1'b0, ftw_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else if (phase_clear_i) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else if (enable_i) begin
            phase_q <= phase_sum[PHASE_W-1:0];
            wrap_q  <= phase_sum[PHASE_W];
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    assign phase_o = phase_q;
    assign wrap_o  = wrap_q;
    assign ftw_o   = ftw_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb/tb_dds_phase_gen.sv - randomized self-checking bench for dds_phase_gen against an arithmetic reference
module tb_dds_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] freq_hz;
    logic        enable;
    logic        phase_clear;
    logic [31:0] phase;
    logic        wrap;
    logic [31:0] ftw;
    logic        busy;

    int checks = 0;
    int errors = 0;

    longint unsigned m_phase;
    longint unsigned m_ftw;
    bit              m_wrap;

    always #5 clk = ~clk;

    dds_phase_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .freq_hz_i     (freq_hz),
        .enable_i      (enable),
        .phase_clear_i (phase_clear),
        .phase_o       (phase),
        .wrap_o        (wrap),
        .ftw_o         (ftw),
        .busy_o        (busy)
    );

    function automatic longint unsigned ftw_ref(input longint unsigned f);
        return (f * 64'd720575940 + 64'd8388608) >> 24;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [32:0] s;
        @(posedge clk);
        #1;
        if (!rst_n || phase_clear) begin
            m_phase = 0;
            m_wrap  = 1'b0;
        end else if (enable) begin
            s       = 33'(m_phase) + 33'(m_ftw);
            m_wrap  = s[32];
            m_phase = longint'(s[31:0]);
        end else begin
            m_wrap  = 1'b0;
        end
        chk("phase", 64'(phase), m_phase);
        chk("wrap", 64'(wrap), 64'(m_wrap));
    endtask

    task automatic settle(input logic [19:0] f);
        phase_clear = 1'b1;
        enable      = 1'b0;
        freq_hz     = f;
        repeat (25) step();
        chk("ftw_settled", 64'(ftw), ftw_ref(64'(f)));
        chk("busy_idle", 64'(busy), 64'd0);
        m_ftw       = ftw_ref(64'(f));
        phase_clear = 1'b0;
    endtask

    task automatic run_acc(input int n);
        for (int i = 0; i < n; i++) begin
            enable      = ($urandom_range(3, 0) != 0);
            phase_clear = ($urandom_range(7, 0) == 0);
            step();
        end
        phase_clear = 1'b0;
    endtask

    task automatic measure_latency(input string tag, input longint unsigned exp_ftw,
                                   input logic [31:0] old_ftw);
        int lat;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            step();
            if (n == 1) chk({tag, "_busy_start"}, 64'(busy), 64'd1);
            if (ftw != old_ftw) lat = n;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd22);
        chk({tag, "_ftw"}, 64'(ftw), exp_ftw);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit saw5, saw6;
        logic [19:0] flist [$];

        rst_n       = 1'b0;
        freq_hz     = '0;
        enable      = 1'b0;
        phase_clear = 1'b1;
        m_phase     = 0;
        m_ftw       = 0;
        m_wrap      = 1'b0;
        #12;
        chk("rst_phase", 64'(phase), 64'd0);
        chk("rst_ftw", 64'(ftw), 64'd0);
        chk("rst_wrap", 64'(wrap), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        freq_hz = 20'd100000;
        measure_latency("f100k", 64'd4294967, 32'd0);

        flist = '{20'd1000, 20'd999000, 20'd1048575, 20'd0};
        repeat (6) flist.push_back(20'($urandom_range(1048575, 0)));
        foreach (flist[i]) begin
            settle(flist[i]);
            run_acc(150);
        end

        settle(20'd999000);
        chk("ftw_999k", 64'(ftw), 64'd42906723);
        enable = 1'b1;
        repeat (10) step();
        phase_clear = 1'b1;
        step();
        phase_clear = 1'b0;
        repeat (5) step();
        enable = 1'b0;
        repeat (5) step();

        settle(20'd0);
        saw5 = 1'b0;
        saw6 = 1'b0;
        phase_clear = 1'b1;
        freq_hz = 20'd5000;
        step();
        repeat (5) step();
        freq_hz = 20'd6000;
        repeat (5) step();
        freq_hz = 20'd7000;
        for (int n = 0; n < 60; n++) begin
            step();
            if (64'(ftw) == ftw_ref(5000)) saw5 = 1'b1;
            if (64'(ftw) == ftw_ref(6000)) saw6 = 1'b1;
        end
        chk("step_seen5000", 64'(saw5), 64'd1);
        chk("step_no6000", 64'(saw6), 64'd0);
        chk("step_ftw7000", 64'(ftw), 64'd300648);

        settle(20'd1000);
        phase_clear = 1'b1;
        freq_hz = 20'd20000;
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midcalc_rst_phase", 64'(phase), 64'd0);
        chk("midcalc_rst_ftw", 64'(ftw), 64'd0);
        chk("midcalc_rst_busy", 64'(busy), 64'd0);
        chk("midcalc_rst_wrap", 64'(wrap), 64'd0);
        m_phase = 0;
        m_wrap  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        measure_latency("f20k", 64'd858993, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
